// File: rtl/lcd_cfah_pkg.sv
// Shared types and default timing for the CFAH character-LCD controller.
// Imported by the bus-cycle engine and the top-level sequencer.
package lcd_cfah_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        BF_SETUP,
        BF_PULSE,
        BF_HOLD,
        BF_GAP,
        DONE
    } t_lcd_state;

    localparam logic C_LCD_ST_OK      = 1'b0;
    localparam logic C_LCD_ST_TIMEOUT = 1'b1;

    localparam int C_T_AS      = 2;
    localparam int C_T_PW      = 12;
    localparam int C_T_H       = 2;
    localparam int C_T_GAP     = 8;
    localparam int C_MAX_POLLS = 255;

    function automatic int f_max4(input int a, input int b,
                                  input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lcd_cfah_bus_cycle.sv
// One LCD bus transaction: optional idle gap, then setup, EN pulse, hold.
// A new start may be chained in the final hold cycle without a bubble.
module lcd_cfah_bus_cycle
    import lcd_cfah_pkg::*;
#(
    parameter int G_T_AS  = C_T_AS,
    parameter int G_T_PW  = C_T_PW,
    parameter int G_T_H   = C_T_H,
    parameter int G_T_GAP = C_T_GAP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       gap,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic       done,
    output logic [7:0] rdata,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic       lcd_data_oe,
    input  logic [7:0] lcd_din
);

    localparam int C_TMAX = f_max4(G_T_AS, G_T_PW, G_T_H, G_T_GAP);
    localparam int TW     = (C_TMAX > 1) ? $clog2(C_TMAX) : 1;

    t_lcd_state    phase, phase_n;
    logic [TW-1:0] tmr, tmr_n;
    logic          rs_n, rw_n, en_n, oe_n, load;
    logic [7:0]    data_n, rdata_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase       <= IDLE;
            tmr         <= '0;
            lcd_rs      <= 1'b0;
            lcd_rw      <= 1'b1;
            lcd_en      <= 1'b0;
            lcd_data    <= 8'h00;
            lcd_data_oe <= 1'b0;
            rdata       <= 8'h00;
        end else begin
            phase       <= phase_n;
            tmr         <= tmr_n;
            lcd_rs      <= rs_n;
            lcd_rw      <= rw_n;
            lcd_en      <= en_n;
            lcd_data    <= data_n;
            lcd_data_oe <= oe_n;
            rdata       <= rdata_n;
        end
    end

    always_comb begin
        phase_n = phase;
        tmr_n   = tmr;
        rs_n    = lcd_rs;
        rw_n    = lcd_rw;
        en_n    = lcd_en;
        data_n  = lcd_data;
        oe_n    = lcd_data_oe;
        rdata_n = rdata;
        done    = 1'b0;
        load    = 1'b0;
        unique case (phase)
            IDLE: load = start;
            BF_GAP:
                if (tmr == '0) begin
                    phase_n = SETUP;
                    tmr_n   = TW'(G_T_AS - 1);
                end else begin
                    tmr_n = tmr - TW'(1);
                end
            SETUP:
                if (tmr == '0) begin
                    en_n    = 1'b1;
                    phase_n = PULSE;
                    tmr_n   = TW'(G_T_PW - 1);
                end else begin
                    tmr_n = tmr - TW'(1);
                end
            PULSE:
                if (tmr == '0) begin
                    en_n    = 1'b0;
                    rdata_n = lcd_din;
                    phase_n = HOLD;
                    tmr_n   = TW'(G_T_H - 1);
                end else begin
                    tmr_n = tmr - TW'(1);
                end
            HOLD:
                if (tmr == '0) begin
                    done    = 1'b1;
                    oe_n    = 1'b0;
                    rw_n    = 1'b1;
                    phase_n = IDLE;
                    load    = start;
                end else begin
                    tmr_n = tmr - TW'(1);
                end
            default: phase_n = IDLE;
        endcase
        // Pins change only while EN is low: in IDLE or at the end of HOLD.
        if (load) begin
            rs_n = rs;
            rw_n = rw;
            oe_n = !rw;
            if (!rw) data_n = wdata;
            if (gap) begin
                phase_n = BF_GAP;
                tmr_n   = TW'(G_T_GAP - 1);
            end else begin
                phase_n = SETUP;
                tmr_n   = TW'(G_T_AS - 1);
            end
        end
    end

endmodule

// File: rtl/lcd_cfah_ctrl.sv
// HD44780-style LCD controller: runs one user cycle, then polls the
// busy flag after writes until it clears or the poll budget runs out.
module lcd_cfah_ctrl
    import lcd_cfah_pkg::*;
#(
    parameter int G_T_AS      = C_T_AS,
    parameter int G_T_PW      = C_T_PW,
    parameter int G_T_H       = C_T_H,
    parameter int G_T_GAP     = C_T_GAP,
    parameter int G_MAX_POLLS = C_MAX_POLLS,
    parameter int G_POLL_EN   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic       i_rw,
    input  logic [7:0] i_wdata,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic       o_status,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_data_oe,
    input  logic [7:0] i_lcd_data
);

    t_lcd_state  state, state_n;
    logic        busy_n, done_n, status_n, rw_q, rw_n;
    logic [7:0]  rdata_n;
    logic [15:0] npoll, npoll_n;

    logic        cyc_start, cyc_gap, cyc_rs, cyc_rw, cyc_done;
    logic [7:0]  cyc_wdata, cyc_rdata;

    lcd_cfah_bus_cycle #(
        .G_T_AS  (G_T_AS),
        .G_T_PW  (G_T_PW),
        .G_T_H   (G_T_H),
        .G_T_GAP (G_T_GAP)
    ) u_bus (
        .clk         (clk),
        .rst         (rst),
        .start       (cyc_start),
        .gap         (cyc_gap),
        .rs          (cyc_rs),
        .rw          (cyc_rw),
        .wdata       (cyc_wdata),
        .done        (cyc_done),
        .rdata       (cyc_rdata),
        .lcd_rs      (o_lcd_rs),
        .lcd_rw      (o_lcd_rw),
        .lcd_en      (o_lcd_en),
        .lcd_data    (o_lcd_data),
        .lcd_data_oe (o_lcd_data_oe),
        .lcd_din     (i_lcd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_rdata  <= 8'h00;
            o_status <= C_LCD_ST_OK;
            npoll    <= 16'd0;
            rw_q     <= 1'b0;
        end else begin
            state    <= state_n;
            o_busy   <= busy_n;
            o_done   <= done_n;
            o_rdata  <= rdata_n;
            o_status <= status_n;
            npoll    <= npoll_n;
            rw_q     <= rw_n;
        end
    end

    always_comb begin
        state_n   = state;
        busy_n    = o_busy;
        done_n    = 1'b0;
        rdata_n   = o_rdata;
        status_n  = o_status;
        npoll_n   = npoll;
        rw_n      = rw_q;
        cyc_start = 1'b0;
        cyc_gap   = 1'b0;
        cyc_rs    = 1'b0;
        cyc_rw    = 1'b1;
        cyc_wdata = i_wdata;
        unique case (state)
            IDLE:
                if (i_start) begin
                    cyc_start = 1'b1;
                    cyc_rs    = i_rs;
                    cyc_rw    = i_rw;
                    rw_n      = i_rw;
                    busy_n    = 1'b1;
                    state_n   = SETUP;
                end
            SETUP:
                if (cyc_done) begin
                    if (rw_q) rdata_n = cyc_rdata;
                    if (!rw_q && G_POLL_EN != 0) begin
                        cyc_start = 1'b1;
                        npoll_n   = 16'd0;
                        state_n   = BF_SETUP;
                    end else begin
                        state_n  = DONE;
                        done_n   = 1'b1;
                        busy_n   = 1'b0;
                        status_n = C_LCD_ST_OK;
                    end
                end
            BF_SETUP:
                if (cyc_done) begin
                    if (!cyc_rdata[7]) begin
                        state_n  = DONE;
                        done_n   = 1'b1;
                        busy_n   = 1'b0;
                        status_n = C_LCD_ST_OK;
                    end else if (npoll + 16'd1 == 16'(G_MAX_POLLS)) begin
                        state_n  = DONE;
                        done_n   = 1'b1;
                        busy_n   = 1'b0;
                        status_n = C_LCD_ST_TIMEOUT;
                    end else begin
                        npoll_n   = npoll + 16'd1;
                        cyc_start = 1'b1;
                        cyc_gap   = 1'b1;
                    end
                end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lcd_cfah_ctrl.sv
// Directed bench for lcd_cfah_ctrl with a small busy-flag LCD model.
// Poll budget is 4 so both clearing and stuck busy flags are reachable.
module tb_lcd_cfah_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_rs = 1'b0;
    logic       i_rw = 1'b0;
    logic [7:0] i_wdata = 8'h00;
    logic       o_busy, o_done, o_status;
    logic [7:0] o_rdata;
    logic       o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_data_oe;
    logic [7:0] o_lcd_data;
    logic [7:0] i_lcd_data;

    int checks = 0;
    int failures = 0;

    // LCD model state
    int         busy_dur = 0;
    int         busy_cnt = 0;
    logic       en_q = 1'b0;
    int         wr_cnt = 0;
    logic [7:0] wr_last = 8'h00;
    logic       wr_rs = 1'b0;
    logic       force_on = 1'b0;
    logic [7:0] force_val = 8'h00;

    lcd_cfah_ctrl #(
        .G_T_AS      (2),
        .G_T_PW      (12),
        .G_T_H       (2),
        .G_T_GAP     (8),
        .G_MAX_POLLS (4),
        .G_POLL_EN   (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_rs          (i_rs),
        .i_rw          (i_rw),
        .i_wdata       (i_wdata),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_rdata       (o_rdata),
        .o_status      (o_status),
        .o_lcd_rs      (o_lcd_rs),
        .o_lcd_rw      (o_lcd_rw),
        .o_lcd_en      (o_lcd_en),
        .o_lcd_data    (o_lcd_data),
        .o_lcd_data_oe (o_lcd_data_oe),
        .i_lcd_data    (i_lcd_data)
    );

    always #5 clk = ~clk;

    assign i_lcd_data = force_on ? force_val
                                 : {(busy_cnt != 0), 7'h00};

    // Write is latched on the EN falling edge, then BF stays set busy_dur.
    always @(posedge clk) begin
        en_q <= o_lcd_en;
        if (en_q && !o_lcd_en && !o_lcd_rw) begin
            wr_cnt   <= wr_cnt + 1;
            wr_last  <= o_lcd_data;
            wr_rs    <= o_lcd_rs;
            busy_cnt <= busy_dur;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic run_cmd(input logic rs, input logic rw,
                           input logic [7:0] wd, input int extra_at,
                           output int lat, output int pulses,
                           output bit oe_seen, output bit busy_next);
        logic en_p;
        int   k;
        @(negedge clk);
        i_rs = rs;
        i_rw = rw;
        i_wdata = wd;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        k = 1;
        busy_next = o_busy;
        lat = 0;
        pulses = 0;
        oe_seen = 1'b0;
        en_p = 1'b0;
        while (lat == 0 && k < 400) begin
            if (o_lcd_en && !en_p) pulses++;
            en_p = o_lcd_en;
            if (o_lcd_data_oe) oe_seen = 1'b1;
            if (o_done) begin
                lat = k + 1;
            end else begin
                if (k == extra_at) begin
                    i_wdata = 8'hFF;
                    i_start = 1'b1;
                end
                @(negedge clk);
                i_start = 1'b0;
                k++;
            end
        end
        if (lat == 0) begin
            checks++;
            failures++;
            $display("FAIL cmd_timeout: no o_done within %0d cycles", k);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({o_busy, o_done, o_status, o_rdata} !== 11'h0) begin
            failures++;
            $display("FAIL reset_ctl: got %b %b %b %h want 0 0 0 00",
                     o_busy, o_done, o_status, o_rdata);
        end
        checks++;
        if ({o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_data_oe} !== 4'b0100) begin
            failures++;
            $display("FAIL reset_pins: got rs/rw/en/oe=%b%b%b%b want 0100",
                     o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_data_oe);
        end
        checks++;
        if (o_lcd_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: got %h want 00", o_lcd_data);
        end
    endtask

    task automatic test_instr_write();
        int lat, pulses, w0;
        bit oe, bn;
        busy_dur = 0;
        force_on = 1'b0;
        w0 = wr_cnt;
        run_cmd(1'b0, 1'b0, 8'h38, 0, lat, pulses, oe, bn);
        checks++;
        if (lat !== 34) begin
            failures++;
            $display("FAIL wr_latency: got %0d want 34", lat);
        end
        checks++;
        if (bn !== 1'b1) begin
            failures++;
            $display("FAIL wr_busy: got %b want 1", bn);
        end
        checks++;
        if (pulses !== 2) begin
            failures++;
            $display("FAIL wr_pulses: got %0d want 2", pulses);
        end
        checks++;
        if (o_status !== 1'b0) begin
            failures++;
            $display("FAIL wr_status: got %b want 0", o_status);
        end
        @(negedge clk);
        checks++;
        if (wr_cnt !== w0 + 1 || wr_last !== 8'h38 || wr_rs !== 1'b0) begin
            failures++;
            $display("FAIL wr_lcd: got n=%0d d=%h rs=%b want n=%0d d=38 rs=0",
                     wr_cnt - w0, wr_last, wr_rs, 1);
        end
    endtask

    task automatic test_user_read();
        int lat, pulses, w0;
        bit oe, bn;
        force_on = 1'b1;
        force_val = 8'h5A;
        w0 = wr_cnt;
        run_cmd(1'b1, 1'b1, 8'h00, 0, lat, pulses, oe, bn);
        checks++;
        if (lat !== 18) begin
            failures++;
            $display("FAIL rd_latency: got %0d want 18", lat);
        end
        checks++;
        if (o_rdata !== 8'h5A) begin
            failures++;
            $display("FAIL rd_data: got %h want 5a", o_rdata);
        end
        checks++;
        if (oe !== 1'b0 || pulses !== 1) begin
            failures++;
            $display("FAIL rd_bus: got oe=%b pulses=%0d want oe=0 pulses=1",
                     oe, pulses);
        end
        checks++;
        if (wr_cnt !== w0) begin
            failures++;
            $display("FAIL rd_nowrite: got %0d writes want 0", wr_cnt - w0);
        end
        force_on = 1'b0;
    endtask

    task automatic test_busy_poll();
        int lat, pulses;
        bit oe, bn;
        busy_dur = 75;
        run_cmd(1'b1, 1'b0, 8'h41, 0, lat, pulses, oe, bn);
        checks++;
        if (pulses !== 5 || lat !== 106) begin
            failures++;
            $display("FAIL poll_timing: got pulses=%0d lat=%0d want 5 106",
                     pulses, lat);
        end
        checks++;
        if (o_status !== 1'b0) begin
            failures++;
            $display("FAIL poll_status: got %b want 0", o_status);
        end
        checks++;
        if (o_rdata !== 8'h5A) begin
            failures++;
            $display("FAIL poll_rdata: got %h want 5a", o_rdata);
        end
        busy_dur = 0;
    endtask

    task automatic test_timeout();
        int lat, pulses;
        bit oe, bn;
        force_on = 1'b1;
        force_val = 8'h80;
        run_cmd(1'b0, 1'b0, 8'h01, 0, lat, pulses, oe, bn);
        checks++;
        if (pulses !== 5 || lat !== 106) begin
            failures++;
            $display("FAIL to_timing: got pulses=%0d lat=%0d want 5 106",
                     pulses, lat);
        end
        checks++;
        if (o_status !== 1'b1) begin
            failures++;
            $display("FAIL to_status: got %b want 1", o_status);
        end
        force_on = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat, pulses, w0, nd;
        bit oe, bn;
        w0 = wr_cnt;
        run_cmd(1'b1, 1'b0, 8'h42, 5, lat, pulses, oe, bn);
        checks++;
        if (lat !== 34) begin
            failures++;
            $display("FAIL b2b_latency: got %0d want 34", lat);
        end
        // Start raised during the DONE cycle must be dropped.
        i_wdata = 8'h55;
        i_rw = 1'b0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL done_start: got busy=%b want 0", o_busy);
        end
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_done) nd++;
        end
        checks++;
        if (nd !== 0) begin
            failures++;
            $display("FAIL b2b_dones: got %0d extra want 0", nd);
        end
        checks++;
        if (wr_cnt !== w0 + 1 || wr_last !== 8'h42) begin
            failures++;
            $display("FAIL b2b_lcd: got n=%0d d=%h want n=1 d=42",
                     wr_cnt - w0, wr_last);
        end
    endtask

    task automatic test_reset_mid();
        int k, nd, lat, pulses;
        bit oe, bn;
        @(negedge clk);
        i_rs = 1'b0;
        i_rw = 1'b0;
        i_wdata = 8'h33;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        k = 0;
        while (!o_lcd_en && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (o_lcd_en !== 1'b1) begin
            failures++;
            $display("FAIL rm_en_wait: got en=%b want 1", o_lcd_en);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({o_lcd_en, o_lcd_data_oe, o_lcd_rw, o_busy} !== 4'b0010) begin
            failures++;
            $display("FAIL rm_pins: got en/oe/rw/busy=%b%b%b%b want 0010",
                     o_lcd_en, o_lcd_data_oe, o_lcd_rw, o_busy);
        end
        checks++;
        if (o_rdata !== 8'h00) begin
            failures++;
            $display("FAIL rm_rdata: got %h want 00", o_rdata);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_done) nd++;
        end
        checks++;
        if (nd !== 0) begin
            failures++;
            $display("FAIL rm_nodone: got %0d dones want 0", nd);
        end
        run_cmd(1'b0, 1'b0, 8'h01, 0, lat, pulses, oe, bn);
        checks++;
        if (lat !== 34 || o_status !== 1'b0) begin
            failures++;
            $display("FAIL rm_after: got lat=%0d st=%b want 34 0",
                     lat, o_status);
        end
        @(negedge clk);
        checks++;
        if (wr_last !== 8'h01) begin
            failures++;
            $display("FAIL rm_lcd: got %h want 01", wr_last);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_instr_write();
        test_user_read();
        test_busy_poll();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
